// File: rtl/config_frame_loader.sv
// Configuration frame loader: shifts a CHUNK-bit beat stream into a CONF_WIDTH shadow word,
// forwards surplus beats down the daisy chain, and pulses cset on commit. Optional macro: CFG_PARITY_EN.
module config_frame_loader #(
    parameter int CONF_WIDTH = 288,
    parameter int CHUNK      = 8,
    parameter int BEATS      = CONF_WIDTH / CHUNK,
    parameter int CNT_W      = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_commit,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHUNK-1:0]      cfg_data,
`ifdef CFG_PARITY_EN
    input  logic                  cfg_par,
`endif
    output logic                  chain_valid,
    input  logic                  chain_ready,
    output logic [CHUNK-1:0]      chain_data,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FULL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                state_q;
    logic [CONF_WIDTH-1:0] shadow_q;
    logic [CNT_W-1:0]      count_q;
    logic                  cset_q;
    logic                  done_q;
    logic                  err_q;
    logic                  frame_bad;

`ifdef CFG_PARITY_EN
    logic bad_q;
    logic par_mismatch;
    // Even parity: cfg_par must equal the XOR of the data bits.
    assign par_mismatch = cfg_par ^ (^cfg_data);
    assign frame_bad    = bad_q;
`else
    assign frame_bad    = 1'b0;
`endif

    // Handshake: a beat moves when valid and ready are both high in the same cycle.
    // In FULL the block is transparent, so ready/valid come straight from the other side.
    assign cfg_ready   = (state_q == LOAD) ? 1'b1 :
                         (state_q == FULL) ? chain_ready : 1'b0;
    assign chain_valid = (state_q == FULL) & cfg_valid;
    assign chain_data  = cfg_data;
    assign c           = shadow_q;
    assign cset        = cset_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            count_q  <= '0;
            cset_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CFG_PARITY_EN
            bad_q    <= 1'b0;
`endif
        end else begin
            cset_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q <= LOAD;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef CFG_PARITY_EN
                        bad_q   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    // A restart takes priority over any beat presented in the same cycle.
                    if (cfg_start) begin
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef CFG_PARITY_EN
                        bad_q   <= 1'b0;
`endif
                    end else if (cfg_commit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (cfg_valid) begin
                        shadow_q <= {cfg_data, shadow_q[CONF_WIDTH-1:CHUNK]};
`ifdef CFG_PARITY_EN
                        if (par_mismatch) bad_q <= 1'b1;
`endif
                        if (count_q == CNT_W'(BEATS - 1)) state_q <= FULL;
                        else count_q <= count_q + 1'b1;
                    end
                end
                FULL: begin
                    if (cfg_start) begin
                        state_q <= LOAD;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef CFG_PARITY_EN
                        bad_q   <= 1'b0;
`endif
                    end else if (cfg_commit) begin
                        if (frame_bad) begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= COMMIT;
                            cset_q  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: reset, frame load/commit, chain pass-through,
// aborted frames, start/commit collision and (with CFG_PARITY_EN) parity errors.
module tb_config_frame_loader;

  localparam int CW = 288;
  localparam int CK = 8;
  localparam int NB = CW / CK;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_commit = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CK-1:0] cfg_data = '0;
  logic          cfg_par = 1'b0;
  logic          chain_valid;
  logic          chain_ready = 1'b0;
  logic [CK-1:0] chain_data;
  logic [CW-1:0] c;
  logic          cset;
  logic          load_done;
  logic          load_err;
  logic [1:0]    dbg_state;

  logic [CW-1:0] exp_c;
  int n_tests = 0;
  int n_fail = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_FULL = 2'd2;

  config_frame_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_commit(cfg_commit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
`ifdef CFG_PARITY_EN
    .cfg_par(cfg_par),
`endif
    .chain_valid(chain_valid), .chain_ready(chain_ready), .chain_data(chain_data),
    .c(c), .cset(cset), .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [CK-1:0] d, input logic flip_par);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_par   = (^d) ^ flip_par;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Beat i carries base + i*step; expected word has beat 0 in the low byte.
  task automatic load_beats(input int n, input int base, input int step, input int bad_idx);
    logic [CK-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = CK'(base + i * step);
      exp_c = {d, exp_c[CW-1:CK]};
      beat(d, i == bad_idx);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (c !== '0) begin n_fail++; $display("FAIL reset_c got %h exp 0", c); end
    n_tests++; if ({cset, load_done, load_err, cfg_ready, chain_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_outs got %b exp 00000", {cset, load_done, load_err, cfg_ready, chain_valid}); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    tick();
    rst = 1'b1;
    tick();
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b exp 0", cfg_ready); end
  endtask

  task automatic test_reset_mid_load();
    exp_c = '0;
    start_frame();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b exp 1", cfg_ready); end
    load_beats(10, 8'h11, 1, -1);
    n_tests++; if (c !== exp_c) begin n_fail++; $display("FAIL mid_load_c got %h exp %h", c, exp_c); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (c !== '0) begin n_fail++; $display("FAIL rst_mid_c got %h exp 0", c); end
    n_tests++; if ({cset, cfg_ready} !== 2'b0) begin n_fail++; $display("FAIL rst_mid_outs got %b exp 00", {cset, cfg_ready}); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_state got %0d exp 0", dbg_state); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    exp_c = '0;
    start_frame();
    load_beats(NB, 0, 1, -1);
    n_tests++; if (dbg_state !== S_FULL) begin n_fail++; $display("FAIL full_state got %0d exp 2", dbg_state); end
    n_tests++; if (c[7:0] !== 8'h00 || c[287:280] !== 8'h23) begin n_fail++; $display("FAIL full_bytes got %h/%h exp 00/23", c[7:0], c[287:280]); end
    n_tests++; if (c !== exp_c) begin n_fail++; $display("FAIL full_c got %h exp %h", c, exp_c); end
    n_tests++; if (cset !== 1'b0) begin n_fail++; $display("FAIL cset_early got %b exp 0", cset); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b1) begin n_fail++; $display("FAIL cset_pulse got %b exp 1", cset); end
    n_tests++; if (c !== exp_c) begin n_fail++; $display("FAIL commit_c got %h exp %h", c, exp_c); end
    tick();
    n_tests++; if (cset !== 1'b0) begin n_fail++; $display("FAIL cset_width got %b exp 0", cset); end
    n_tests++; if (load_done !== 1'b1 || load_err !== 1'b0) begin n_fail++; $display("FAIL done_flags got %b%b exp 10", load_done, load_err); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL post_commit_state got %0d exp 0", dbg_state); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b0) begin n_fail++; $display("FAIL idle_commit_cset got %b exp 0", cset); end
  endtask

  task automatic test_pass_through();
    logic rdy [5];
    logic [CK-1:0] d;
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_c = '0;
    start_frame();
    n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL start_clears_done got %b exp 0", load_done); end
    load_beats(NB, 8'h03, 7, -1);
    for (int k = 0; k < 5; k++) begin
      d = CK'(8'hA0 + k);
      cfg_valid = 1'b1; cfg_data = d; cfg_par = ^d; chain_ready = rdy[k];
      #1;
      n_tests++; if (chain_valid !== 1'b1 || chain_data !== d) begin n_fail++; $display("FAIL chain_fwd[%0d] got %b/%h exp 1/%h", k, chain_valid, chain_data, d); end
      n_tests++; if (cfg_ready !== rdy[k]) begin n_fail++; $display("FAIL ready_mirror[%0d] got %b exp %b", k, cfg_ready, rdy[k]); end
      tick();
    end
    cfg_valid = 1'b0; chain_ready = 1'b0;
    #1;
    n_tests++; if (chain_valid !== 1'b0) begin n_fail++; $display("FAIL chain_idle got %b exp 0", chain_valid); end
    n_tests++; if (c !== exp_c) begin n_fail++; $display("FAIL shadow_kept got %h exp %h", c, exp_c); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b1 || c !== exp_c) begin n_fail++; $display("FAIL pass_commit got cset=%b c=%h exp 1/%h", cset, c, exp_c); end
    tick();
  endtask

  task automatic test_abort();
    exp_c = '0;
    start_frame();
    load_beats(20, 8'h40, 1, -1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b0 || load_err !== 1'b1) begin n_fail++; $display("FAIL abort got cset=%b err=%b exp 0/1", cset, load_err); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL abort_state got %0d exp 0", dbg_state); end
    tick();
    n_tests++; if (cset !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL abort_late got cset=%b done=%b exp 0/0", cset, load_done); end
    start_frame();
    n_tests++; if (load_err !== 1'b0 || dbg_state !== S_LOAD) begin n_fail++; $display("FAIL abort_restart got err=%b st=%0d exp 0/1", load_err, dbg_state); end
  endtask

  task automatic test_start_commit_collision();
    exp_c = '0;
    load_beats(NB, 8'h80, 3, -1);
    n_tests++; if (dbg_state !== S_FULL) begin n_fail++; $display("FAIL coll_full got %0d exp 2", dbg_state); end
    cfg_start = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b0 || dbg_state !== S_LOAD) begin n_fail++; $display("FAIL coll got cset=%b st=%0d exp 0/1", cset, dbg_state); end
    tick();
    n_tests++; if (cset !== 1'b0) begin n_fail++; $display("FAIL coll_late got %b exp 0", cset); end
    load_beats(NB - 1, 8'h05, 1, -1);
    n_tests++; if (dbg_state !== S_LOAD) begin n_fail++; $display("FAIL coll_count35 got %0d exp 1", dbg_state); end
    load_beats(1, 8'h77, 0, -1);
    n_tests++; if (dbg_state !== S_FULL || c !== exp_c) begin n_fail++; $display("FAIL coll_count36 got st=%0d c=%h exp 2/%h", dbg_state, c, exp_c); end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    exp_c = '0;
    start_frame();
    load_beats(NB, 8'h10, 1, 7);
    n_tests++; if (dbg_state !== S_FULL) begin n_fail++; $display("FAIL par_full got %0d exp 2", dbg_state); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b0 || load_err !== 1'b1 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL par_err got cset=%b err=%b st=%0d exp 0/1/0", cset, load_err, dbg_state); end
    exp_c = '0;
    start_frame();
    load_beats(NB, 8'h10, 1, -1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++; if (cset !== 1'b1) begin n_fail++; $display("FAIL par_clean got %b exp 1", cset); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_load();
    test_full_load();
    test_pass_through();
    test_abort();
    test_start_commit_collision();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
